// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg -- shared core definitions.
// Holds the immediate-format codes used by both the instruction encoder and the
// immediate decoder, plus the build-time range-check switch.
// Build macro: IMM_RANGE_CHECK_EN (defined -> immediate range checking and error
// counting active; undefined -> RANGE_ERR/ERR_COUNT tied to zero).
package instr_encoder_pkg;

    // Immediate format selector; code 3'b111 is reserved and encodes like I-type
    typedef enum logic [2:0] {
        IMM_R    = 3'b000,
        IMM_I    = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_U    = 3'b100,
        IMM_J    = 3'b101,
        IMM_CSR  = 3'b110,
        IMM_RSVD = 3'b111
    } imm_type_e;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    // True when v[XLEN-1:lo] are all copies of the same bit, i.e. v is a valid
    // sign extension of its low lo+1 bits.
    function automatic logic sign_fits(input logic [XLEN-1:0] v, input int unsigned lo);
        logic [XLEN-1:0] s;
        s = $unsigned($signed(v) >>> lo);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// imm_packer -- combinational immediate placement and representability check.
// Overlays the immediate bits of the selected format onto the template word;
// every other bit passes through from the template unchanged.
// Build macro: IMM_RANGE_CHECK_EN (undefined -> range_err is constant 0).
module imm_packer
    import instr_encoder_pkg::*;
(
    input  imm_type_e         imm_type,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   tmpl,
    output logic [XLEN-1:0]   instr,
    output logic              range_err
);

    logic fail;

    // Scatter immediate bits into the format's slots and flag values that lose information
    always_comb begin
        instr = tmpl;
        fail  = 1'b0;
        case (imm_type)
            IMM_R: begin
                fail = 1'b0;
            end
            IMM_I, IMM_RSVD: begin
                instr[31:20] = imm[11:0];
                fail         = !sign_fits(imm, 11);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                fail         = !sign_fits(imm, 11);
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                fail         = !sign_fits(imm, 12) || imm[0];
            end
            IMM_U: begin
                instr[31:12] = imm[31:12];
                fail         = |imm[11:0];
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                fail         = !sign_fits(imm, 20) || imm[0];
            end
            IMM_CSR: begin
                instr[19:15] = imm[4:0];
                fail         = |imm[31:5];
            end
            default: begin
                fail = 1'b0;
            end
        endcase
    end

    assign range_err = RANGE_CHECK_EN && fail;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- two-stage valid/ready instruction encoder.
// S1 captures the request, imm_packer encodes between S1 and S2, S2 holds the
// result presented on INSTR/RANGE_ERR. Saturating counters track delivered words
// and delivered words flagged out of range.
// Build macro: IMM_RANGE_CHECK_EN (undefined -> RANGE_ERR and ERR_COUNT stay 0).
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       IMM_TYPE,
    input  logic [XLEN-1:0]  IMM,
    input  logic [XLEN-1:0]  TEMPLATE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  INSTR,
    output logic             RANGE_ERR,
    input  logic             CLR_CNT,
    output logic [CNT_W-1:0] ENC_COUNT,
    output logic [CNT_W-1:0] ERR_COUNT
);

    logic            s1_valid;
    imm_type_e       s1_type;
    logic [XLEN-1:0] s1_imm;
    logic [XLEN-1:0] s1_tmpl;

    logic            s2_valid;
    logic [XLEN-1:0] s2_instr;
    logic            s2_err;

    logic [XLEN-1:0] pk_instr;
    logic            pk_err;

    logic            in_hs;
    logic            s2_load;
    logic            out_hs;

    // S1 can take a new request whenever it is empty, or it can drain into S2
    assign IN_READY = !s1_valid || !s2_valid || OUT_READY;
    assign in_hs    = IN_VALID && IN_READY;
    assign s2_load  = s1_valid && (!s2_valid || OUT_READY);
    assign out_hs   = s2_valid && OUT_READY;

    imm_packer u_imm_packer (
        .imm_type  (s1_type),
        .imm       (s1_imm),
        .tmpl      (s1_tmpl),
        .instr     (pk_instr),
        .range_err (pk_err)
    );

    // Stage 1: capture the request; empties when its word moves to S2 with nothing new behind it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_type  <= IMM_R;
            s1_imm   <= '0;
            s1_tmpl  <= '0;
        end else if (in_hs) begin
            s1_valid <= 1'b1;
            s1_type  <= imm_type_e'(IMM_TYPE);
            s1_imm   <= IMM;
            s1_tmpl  <= TEMPLATE;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: hold the encoded word stable until the consumer takes it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_instr <= pk_instr;
            s2_err   <= pk_err;
        end else if (OUT_READY) begin
            s2_valid <= 1'b0;
        end
    end

    assign OUT_VALID = s2_valid;
    assign INSTR     = s2_instr;
    assign RANGE_ERR = s2_err;

    // Delivered-word counter; a clear in the same cycle as a handshake wins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ENC_COUNT <= '0;
        end else if (CLR_CNT) begin
            ENC_COUNT <= '0;
        end else if (out_hs && (ENC_COUNT != '1)) begin
            ENC_COUNT <= ENC_COUNT + 1'b1;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    // Out-of-range delivered-word counter; same clear and saturation rules as ENC_COUNT
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR_COUNT <= '0;
        end else if (CLR_CNT) begin
            ERR_COUNT <= '0;
        end else if (out_hs && s2_err && (ERR_COUNT != '1)) begin
            ERR_COUNT <= ERR_COUNT + 1'b1;
        end
    end
`else
    assign ERR_COUNT = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder -- self-checking bench for instr_encoder.
// Fixed vectors, backpressure, random traffic against a field-map reference
// model, counter saturation/clear and mid-stream reset.
// Honours IMM_RANGE_CHECK_EN the same way as the design build.
module tb_instr_encoder;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  IMM_TYPE;
    logic [31:0] IMM;
    logic [31:0] TEMPLATE;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INSTR;
    logic        RANGE_ERR;
    logic        CLR_CNT;
    logic [15:0] ENC_COUNT;
    logic [15:0] ERR_COUNT;

    instr_encoder dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IMM_TYPE  (IMM_TYPE),
        .IMM       (IMM),
        .TEMPLATE  (TEMPLATE),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .INSTR     (INSTR),
        .RANGE_ERR (RANGE_ERR),
        .CLR_CNT   (CLR_CNT),
        .ENC_COUNT (ENC_COUNT),
        .ERR_COUNT (ERR_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] imm;
        logic [31:0] tmpl;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] imm;
        logic [31:0] tmpl;
    } req_t;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        raw_err;
        logic        err;
        int unsigned age;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   enc_m  = 0;
    int   err_m  = 0;
    int   accepted = 0;
    req_t pend[$];
    exp_t sb[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
        logic [31:0] s;
        s = v << (32 - w);
        return $unsigned($signed(s) >>> (32 - w));
    endfunction

    // Overwrite word[hi:lo] with imm bits starting at ilo
    function automatic logic [31:0] put(input logic [31:0] w, input logic [31:0] imm,
                                        input int unsigned hi, input int unsigned lo,
                                        input int unsigned ilo);
        logic [31:0] m;
        m = (32'h1 << (hi - lo + 1)) - 32'h1;
        return (w & ~(m << lo)) | (((imm >> ilo) & m) << lo);
    endfunction

    function automatic logic [31:0] model_instr(input logic [2:0] t, input logic [31:0] imm,
                                                input logic [31:0] tm);
        logic [31:0] w;
        w = tm;
        case (t)
            3'd0: w = tm;
            3'd2: begin w = put(w, imm, 31, 25, 5); w = put(w, imm, 11, 7, 0); end
            3'd3: begin
                w = put(w, imm, 31, 31, 12); w = put(w, imm, 7, 7, 11);
                w = put(w, imm, 30, 25, 5);  w = put(w, imm, 11, 8, 1);
            end
            3'd4: w = put(w, imm, 31, 12, 12);
            3'd5: begin
                w = put(w, imm, 31, 31, 20); w = put(w, imm, 30, 21, 1);
                w = put(w, imm, 20, 20, 11); w = put(w, imm, 19, 12, 12);
            end
            3'd6: w = put(w, imm, 19, 15, 0);
            default: w = put(w, imm, 31, 20, 0);
        endcase
        return w;
    endfunction

    function automatic logic model_err(input logic [2:0] t, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (t)
            3'd0: return 1'b0;
            3'd3: return !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
            3'd4: return (imm % 4096) != 0;
            3'd5: return !(s >= -1048576 && s <= 1048575) || (imm % 2 != 0);
            3'd6: return imm >= 32;
            default: return !(s >= -2048 && s <= 2047);
        endcase
    endfunction

    // Immediate decoder used for the round-trip check
    function automatic logic [31:0] decode_imm(input logic [2:0] t, input logic [31:0] w);
        case (t)
            3'd2: return sext({20'd0, w[31:25], w[11:7]}, 12);
            3'd3: return sext({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
            3'd4: return {w[31:12], 12'd0};
            3'd5: return sext({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
            3'd6: return {27'd0, w[19:15]};
            default: return sext({20'd0, w[31:20]}, 12);
        endcase
    endfunction

    function automatic logic [31:0] rand_imm(input logic [2:0] t);
        logic [31:0] v;
        int unsigned sel;
        v   = $urandom;
        sel = $urandom_range(0, 3);
        if (sel == 0) return v;
        case (t)
            3'd3: v = sext(v, 13);
            3'd4: v = v & 32'hFFFFF000;
            3'd5: v = sext(v, 21);
            3'd6: v = $urandom_range(0, 31);
            default: v = sext(v, 12);
        endcase
        if (sel != 1 && (t == 3'd3 || t == 3'd5)) v[0] = 1'b0;
        return v;
    endfunction

    task automatic observe();
        logic exp_ov;
        exp_t e;
        req_t r;
        for (int i = 0; i < sb.size(); i++) sb[i].age = sb[i].age + 1;
        exp_ov = (sb.size() > 0) && (sb[0].age >= 2);
        chk("in_ready", IN_READY, (sb.size() < 2) || OUT_READY);
        chk("out_valid", OUT_VALID, exp_ov);
        if (exp_ov && OUT_VALID) begin
            chk("instr", INSTR, sb[0].instr);
            chk("range_err", RANGE_ERR, sb[0].err);
            if (OUT_READY) begin
                e = sb.pop_front();
                if (e.typ != 3'd0 && !e.raw_err)
                    chk("roundtrip", decode_imm(e.typ, INSTR), e.imm);
                if (enc_m < 65535) enc_m++;
                if (e.err && err_m < 65535) err_m++;
            end
        end
        if (IN_VALID && IN_READY) begin
            r = pend.pop_front();
            e.typ     = r.typ;
            e.imm     = r.imm;
            e.instr   = model_instr(r.typ, r.imm, r.tmpl);
            e.raw_err = model_err(r.typ, r.imm);
            e.err     = e.raw_err & CHK_EN;
            e.age     = 0;
            sb.push_back(e);
            accepted++;
        end
    endtask

    task automatic step(input bit in_v, input bit out_r);
        if (in_v && pend.size() > 0) begin
            IN_VALID = 1'b1;
            IMM_TYPE = pend[0].typ;
            IMM      = pend[0].imm;
            TEMPLATE = pend[0].tmpl;
        end else begin
            IN_VALID = 1'b0;
        end
        OUT_READY = out_r;
        @(negedge CLK);
        observe();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int unsigned budget);
        for (int unsigned c = 0; c < budget && (pend.size() > 0 || sb.size() > 0); c++)
            step(1'b1, 1'b1);
        chk("drain_timeout", pend.size() + sb.size(), 0);
    endtask

    task automatic clear_counters();
        IN_VALID = 1'b0;
        CLR_CNT  = 1'b1;
        @(posedge CLK); #1;
        CLR_CNT = 1'b0;
        enc_m = 0;
        err_m = 0;
        chk("clr_enc", ENC_COUNT, 0);
        chk("clr_err", ERR_COUNT, 0);
    endtask

    initial begin
        int n_err;
        req_t r;

        vecs[0]  = '{3'd1, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0};
        vecs[1]  = '{3'd2, 32'h000007FF, 32'h00002023, 32'h7E002FA3, 1'b0};
        vecs[2]  = '{3'd3, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0};
        vecs[3]  = '{3'd5, 32'h00000008, 32'h0000006F, 32'h0080006F, 1'b0};
        vecs[4]  = '{3'd1, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
        vecs[5]  = '{3'd3, 32'h00000005, 32'h00000063, 32'h00000263, 1'b1};
        vecs[6]  = '{3'd4, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0};
        vecs[7]  = '{3'd4, 32'h00000FFF, 32'h00000037, 32'h00000037, 1'b1};
        vecs[8]  = '{3'd6, 32'h0000001F, 32'h30001073, 32'h300F9073, 1'b0};
        vecs[9]  = '{3'd6, 32'h00000020, 32'h00005073, 32'h00005073, 1'b1};
        vecs[10] = '{3'd0, 32'hDEADBEEF, 32'h00B50533, 32'h00B50533, 1'b0};
        vecs[11] = '{3'd7, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0};
        vecs[12] = '{3'd1, 32'h00000001, 32'hFFF00013, 32'h00100013, 1'b0};
        vecs[13] = '{3'd5, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};

        RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; CLR_CNT = 1'b0;
        IMM_TYPE = 3'd0; IMM = '0; TEMPLATE = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_instr", INSTR, 0);
        chk("rst_range_err", RANGE_ERR, 0);
        chk("rst_enc", ENC_COUNT, 0);
        chk("rst_err", ERR_COUNT, 0);
        @(posedge CLK); #1;

        // Fixed vectors: one request at a time, exact two-cycle latency
        n_err = 0;
        for (int i = 0; i < 14; i++) begin
            IMM_TYPE = vecs[i].typ; IMM = vecs[i].imm; TEMPLATE = vecs[i].tmpl;
            IN_VALID = 1'b1; OUT_READY = 1'b1;
            @(negedge CLK);
            chk("tbl_in_ready", IN_READY, 1);
            @(posedge CLK); #1;
            IN_VALID = 1'b0;
            @(negedge CLK);
            chk("tbl_early_valid", OUT_VALID, 0);
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("tbl_out_valid", OUT_VALID, 1);
            chk("tbl_instr", INSTR, vecs[i].instr);
            chk("tbl_range_err", RANGE_ERR, vecs[i].err & CHK_EN);
            if (vecs[i].err) n_err++;
            @(posedge CLK); #1;
        end
        chk("tbl_enc_count", ENC_COUNT, 14);
        chk("tbl_err_count", ERR_COUNT, CHK_EN ? n_err : 0);
        clear_counters();

        // Backpressure: four back-to-back requests, consumer stalled three cycles
        for (int i = 0; i < 4; i++) begin
            r.typ = 3'd1; r.imm = 32'(i * 3 + 1); r.tmpl = 32'h00000013 | (32'(i) << 7);
            pend.push_back(r);
        end
        accepted = 0;
        repeat (3) step(1'b1, 1'b0);
        chk("bp_accepted", accepted, 2);
        chk("bp_in_ready_low", IN_READY, 0);
        drain(20);
        chk("bp_enc_count", ENC_COUNT, 4);
        chk("bp_err_count", ERR_COUNT, 0);

        // Random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            r.typ  = 3'($urandom_range(0, 7));
            r.imm  = rand_imm(r.typ);
            r.tmpl = $urandom;
            pend.push_back(r);
        end
        for (int c = 0; c < 20000 && pend.size() > 0; c++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        drain(50);
        chk("rnd_enc_count", ENC_COUNT, enc_m);
        chk("rnd_err_count", ERR_COUNT, err_m);

        // Saturation and clear-wins
        IMM_TYPE = 3'd0; IMM = '0; TEMPLATE = 32'h00000033;
        IN_VALID = 1'b1; OUT_READY = 1'b1; CLR_CNT = 1'b1;
        @(posedge CLK); #1;
        CLR_CNT = 1'b0;
        repeat (65545) @(posedge CLK);
        #1;
        chk("sat_enc", ENC_COUNT, 16'hFFFF);
        chk("sat_err", ERR_COUNT, 0);
        CLR_CNT = 1'b1;
        @(posedge CLK); #1;
        CLR_CNT = 1'b0;
        chk("clr_with_hs", ENC_COUNT, 0);
        @(posedge CLK); #1;
        chk("count_after_clr", ENC_COUNT, 1);
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        enc_m = 0; err_m = 0;

        // Mid-stream reset with both stages full
        for (int i = 0; i < 3; i++) begin
            r.typ = 3'd4; r.imm = 32'(i + 1) << 12; r.tmpl = 32'h00000037;
            pend.push_back(r);
        end
        repeat (3) step(1'b1, 1'b0);
        chk("pre_rst_full", OUT_VALID, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mrst_out_valid", OUT_VALID, 0);
        chk("mrst_instr", INSTR, 0);
        chk("mrst_range_err", RANGE_ERR, 0);
        chk("mrst_enc", ENC_COUNT, 0);
        chk("mrst_err", ERR_COUNT, 0);
        pend.delete(); sb.delete();
        enc_m = 0; err_m = 0;
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("mrst_in_ready", IN_READY, 1);
        @(posedge CLK); #1;
        repeat (4) step(1'b0, 1'b1);
        r.typ = 3'd2; r.imm = 32'hFFFFFFF0; r.tmpl = 32'h00002023;
        pend.push_back(r);
        drain(10);
        chk("post_rst_enc", ENC_COUNT, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
